adc_cmd_sequencer: RTL and testbench

Command sequencer between the UART command decoder and the ADC core/UART transmitter. It accepts one decoded command per strobe and runs one of three sequences. Calibrate runs one calibration handshake. Sample runs NUM_SAMPLES conversions and streams each result as two bytes. Any other command code returns a NAK byte. Every sequence ends with exactly one ACK or NAK status byte.

---
 rtl/adc_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_adc_cmd_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cmd_sequencer.sv
// Command sequencer: turns decoded UART commands into calibration or
// conversion handshakes and streams results/status bytes to the UART.
module adc_cmd_sequencer #(
    parameter int         CMDLENGTH   = 4,
    parameter int         ADC_BITS    = 12,
    parameter int         NUM_SAMPLES = 16,
    parameter int         TIMEOUT     = 65535,
    parameter logic [7:0] ACK_BYTE    = 8'hA5,
    parameter logic [7:0] NAK_BYTE    = 8'hEE
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 sys_locked,
    input  logic [CMDLENGTH-1:0] cmd,
    input  logic                 cmd_vld,
    output logic                 cal_start,
    input  logic                 cal_done,
    output logic                 adc_start,
    input  logic                 adc_done,
    input  logic [ADC_BITS-1:0]  adc_data,
    output logic [7:0]           tx_data,
    output logic                 tx_req,
    input  logic                 tx_busy,
    output logic                 busy,
    output logic                 err
);

    localparam int CNT_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]     LAST_SAMPLE = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LIMIT  = WAIT_W'(TIMEOUT);
    localparam logic [CMDLENGTH-1:0] CMD_CAL     = CMDLENGTH'(1);
    localparam logic [CMDLENGTH-1:0] CMD_SAMPLE  = CMDLENGTH'(2);

    typedef enum logic [3:0] {
        IDLE,
        CAL_START,
        CAL_WAIT,
        CONV_START,
        CONV_WAIT,
        TX_HI,
        TX_HI_G,
        TX_LO,
        TX_LO_G,
        TX_STAT
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]    sample_cnt, sample_cnt_nxt;
    logic [ADC_BITS-1:0] sample_q, sample_q_nxt;
    logic [7:0]          stat_byte, stat_byte_nxt;
    logic [7:0]          tx_data_nxt;
    logic                tx_req_nxt;
    logic                err_nxt;
    logic                cal_start_nxt;
    logic                adc_start_nxt;
    logic                busy_nxt;
    logic [15:0]         sample_wide;

    assign sample_wide = 16'(sample_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            sample_cnt <= '0;
            sample_q   <= '0;
            stat_byte  <= 8'h00;
            tx_data    <= 8'h00;
            tx_req     <= 1'b0;
            err        <= 1'b0;
            cal_start  <= 1'b0;
            adc_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            sample_cnt <= sample_cnt_nxt;
            sample_q   <= sample_q_nxt;
            stat_byte  <= stat_byte_nxt;
            tx_data    <= tx_data_nxt;
            tx_req     <= tx_req_nxt;
            err        <= err_nxt;
            cal_start  <= cal_start_nxt;
            adc_start  <= adc_start_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        sample_cnt_nxt = sample_cnt;
        sample_q_nxt   = sample_q;
        stat_byte_nxt  = stat_byte;
        tx_data_nxt    = tx_data;
        tx_req_nxt     = 1'b0;
        err_nxt        = err;

        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    err_nxt = 1'b0;
                    if (cmd == CMD_CAL) begin
                        state_nxt = CAL_START;
                    end else if (cmd == CMD_SAMPLE) begin
                        sample_cnt_nxt = '0;
                        state_nxt      = CONV_START;
                    end else begin
                        stat_byte_nxt = NAK_BYTE;
                        state_nxt     = TX_STAT;
                    end
                end
            end
            CAL_START: begin
                wait_cnt_nxt = '0;
                state_nxt    = CAL_WAIT;
            end
            CAL_WAIT: begin
                if (cal_done) begin
                    stat_byte_nxt = ACK_BYTE;
                    state_nxt     = TX_STAT;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    err_nxt       = 1'b1;
                    stat_byte_nxt = NAK_BYTE;
                    state_nxt     = TX_STAT;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            CONV_START: begin
                wait_cnt_nxt = '0;
                state_nxt    = CONV_WAIT;
            end
            CONV_WAIT: begin
                if (adc_done) begin
                    sample_q_nxt = adc_data;
                    state_nxt    = TX_HI;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    err_nxt       = 1'b1;
                    stat_byte_nxt = NAK_BYTE;
                    state_nxt     = TX_STAT;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            TX_HI: begin
                if (!tx_busy) begin
                    tx_data_nxt = sample_wide[15:8];
                    tx_req_nxt  = 1'b1;
                    state_nxt   = TX_HI_G;
                end
            end
            // The UART only raises tx_busy a cycle after our request, so the
            // guard states skip that stale low value.
            TX_HI_G: begin
                state_nxt = TX_LO;
            end
            TX_LO: begin
                if (!tx_busy) begin
                    tx_data_nxt = sample_wide[7:0];
                    tx_req_nxt  = 1'b1;
                    state_nxt   = TX_LO_G;
                end
            end
            TX_LO_G: begin
                if (sample_cnt == LAST_SAMPLE) begin
                    stat_byte_nxt = ACK_BYTE;
                    state_nxt     = TX_STAT;
                end else begin
                    sample_cnt_nxt = sample_cnt + CNT_W'(1);
                    state_nxt      = CONV_START;
                end
            end
            TX_STAT: begin
                if (!tx_busy) begin
                    tx_data_nxt = stat_byte;
                    tx_req_nxt  = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Losing clock lock aborts everything back to the reset picture.
        if (!sys_locked) begin
            state_nxt      = IDLE;
            wait_cnt_nxt   = '0;
            sample_cnt_nxt = '0;
            sample_q_nxt   = '0;
            stat_byte_nxt  = 8'h00;
            tx_data_nxt    = 8'h00;
            tx_req_nxt     = 1'b0;
            err_nxt        = 1'b0;
        end
    end

    // Start pulses last exactly the single cycle spent in a start state;
    // busy stays up through the final status request.
    always_comb begin
        cal_start_nxt = (state_nxt == CAL_START);
        adc_start_nxt = (state_nxt == CONV_START);
        busy_nxt      = (state_nxt != IDLE) || tx_req_nxt;
    end

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Scoreboard bench for adc_cmd_sequencer: directed commands, a UART busy model
// and ADC/calibration responders feeding an expected-byte queue.
module tb_adc_cmd_sequencer;

    localparam int CMDLENGTH   = 4;
    localparam int ADC_BITS    = 12;
    localparam int NUM_SAMPLES = 4;
    localparam int TIMEOUT     = 20;
    localparam int BUSY_LEN    = 8;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic                 sys_locked;
    logic [CMDLENGTH-1:0] cmd;
    logic                 cmd_vld;
    logic                 cal_start;
    logic                 cal_done;
    logic                 adc_start;
    logic                 adc_done;
    logic [ADC_BITS-1:0]  adc_data;
    logic [7:0]           tx_data;
    logic                 tx_req;
    logic                 tx_busy;
    logic                 busy;
    logic                 err;

    int checks = 0;
    int errors = 0;
    int cal_pulses = 0;
    int adc_pulses = 0;
    int busy_cnt = 0;
    logic [7:0]          exp_q[$];
    logic [ADC_BITS-1:0] adc_vals[$];
    bit cal_auto = 1'b0;
    bit adc_auto = 1'b0;
    int cal_delay = 10;
    int adc_delay = 3;

    always #5 clk = ~clk;

    adc_cmd_sequencer #(
        .CMDLENGTH  (CMDLENGTH),
        .ADC_BITS   (ADC_BITS),
        .NUM_SAMPLES(NUM_SAMPLES),
        .TIMEOUT    (TIMEOUT),
        .ACK_BYTE   (8'hA5),
        .NAK_BYTE   (8'hEE)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .sys_locked(sys_locked),
        .cmd       (cmd),
        .cmd_vld   (cmd_vld),
        .cal_start (cal_start),
        .cal_done  (cal_done),
        .adc_start (adc_start),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .err       (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Called on a falling edge: strobes cmd for cycle 0, returns mid-cycle 1.
    task automatic applyStimulus(input logic [CMDLENGTH-1:0] code);
        cmd     = code;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || tx_busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_idle", 32'(n < budget), 32'd1);
    endtask

    // Scoreboard monitor plus UART busy model, kept in one process so the
    // busy check always sees the value the DUT sampled.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_req === 1'b1) begin
                checkOutput("tx_req_while_busy", 32'(tx_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tx_req: actual=%0h expected=none", tx_data);
                end else begin
                    checkOutput("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                tx_busy  = 1'b1;
                busy_cnt = BUSY_LEN;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cal_start === 1'b1) cal_pulses++;
            if (adc_start === 1'b1) adc_pulses++;
        end
    end

    initial begin
        cal_done = 1'b0;
        forever begin
            @(negedge clk);
            if (cal_start === 1'b1 && cal_auto) begin
                repeat (cal_delay) @(negedge clk);
                cal_done = 1'b1;
                @(negedge clk);
                cal_done = 1'b0;
            end
        end
    end

    // ADC responder; also checks the high byte follows adc_done by two cycles
    // whenever the UART was idle.
    initial begin : adc_model
        logic busy_at;
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1 && adc_auto) begin
                repeat (adc_delay) @(negedge clk);
                adc_data = (adc_vals.size() > 0) ? adc_vals.pop_front() : '0;
                adc_done = 1'b1;
                @(negedge clk);
                adc_done = 1'b0;
                @(posedge clk);
                busy_at = tx_busy;
                @(negedge clk);
                if (!busy_at) checkOutput("hi_byte_latency", 32'(tx_req), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_cal;
        int base_adc;
        int n;

        nrst       = 1'b0;
        sys_locked = 1'b1;
        cmd        = '0;
        cmd_vld    = 1'b0;
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_tx_req", 32'(tx_req), 32'd0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
        checkOutput("reset_cal_start", 32'(cal_start), 32'd0);
        checkOutput("reset_adc_start", 32'(adc_start), 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] calibrate with cal_done after 10 cycles");
        base_cal = cal_pulses; base_adc = adc_pulses;
        cal_auto = 1'b1; cal_delay = 10;
        exp_q.push_back(8'hA5);
        applyStimulus(4'h1);
        checkOutput("cal_start_cycle1", 32'(cal_start), 32'd1);
        checkOutput("cal_busy_cycle1", 32'(busy), 32'd1);
        waitIdle(200);
        checkOutput("cal_pulse_count", 32'(cal_pulses - base_cal), 32'd1);
        checkOutput("cal_no_adc_start", 32'(adc_pulses - base_adc), 32'd0);
        checkOutput("cal_err", 32'(err), 32'd0);
        checkOutput("cal_busy_after", 32'(busy), 32'd0);

        $display("[TB] sample four conversions");
        base_cal = cal_pulses; base_adc = adc_pulses;
        adc_auto = 1'b1; adc_delay = 3;
        adc_vals = '{12'hABC, 12'h001, 12'hFFF, 12'h800};
        exp_q = '{8'h0A, 8'hBC, 8'h00, 8'h01, 8'h0F, 8'hFF, 8'h08, 8'h00, 8'hA5};
        applyStimulus(4'h2);
        checkOutput("adc_start_cycle1", 32'(adc_start), 32'd1);
        checkOutput("sample_busy_cycle1", 32'(busy), 32'd1);
        waitIdle(600);
        checkOutput("sample_adc_pulses", 32'(adc_pulses - base_adc), 32'd4);
        checkOutput("sample_err", 32'(err), 32'd0);

        $display("[TB] unknown command");
        base_cal = cal_pulses; base_adc = adc_pulses;
        exp_q.push_back(8'hEE);
        applyStimulus(4'h7);
        checkOutput("nak_busy_cycle1", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("nak_tx_req_cycle2", 32'(tx_req), 32'd1);
        checkOutput("nak_tx_data_cycle2", 32'(tx_data), 32'hEE);
        checkOutput("nak_busy_cycle2", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("nak_busy_cycle3", 32'(busy), 32'd0);
        waitIdle(100);
        checkOutput("nak_no_cal", 32'(cal_pulses - base_cal), 32'd0);
        checkOutput("nak_no_adc", 32'(adc_pulses - base_adc), 32'd0);

        $display("[TB] conversion timeout then calibrate");
        base_adc = adc_pulses;
        adc_auto = 1'b0;
        exp_q.push_back(8'hEE);
        applyStimulus(4'h2);
        repeat (21) @(negedge clk);
        checkOutput("timeout_err_before", 32'(err), 32'd0);
        @(negedge clk);
        checkOutput("timeout_err_set", 32'(err), 32'd1);
        waitIdle(100);
        checkOutput("timeout_err_sticky", 32'(err), 32'd1);
        checkOutput("timeout_adc_pulses", 32'(adc_pulses - base_adc), 32'd1);
        cal_delay = 10;
        exp_q.push_back(8'hA5);
        applyStimulus(4'h1);
        checkOutput("err_cleared_on_accept", 32'(err), 32'd0);
        waitIdle(200);
        checkOutput("err_after_cal", 32'(err), 32'd0);

        $display("[TB] command during sample stream is ignored");
        base_cal = cal_pulses; base_adc = adc_pulses;
        adc_auto = 1'b1;
        adc_vals = '{12'h123, 12'h456, 12'h789, 12'h0FF};
        exp_q = '{8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h00, 8'hFF, 8'hA5};
        applyStimulus(4'h2);
        repeat (6) @(negedge clk);
        cmd = 4'h1; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        waitIdle(600);
        checkOutput("ignored_cmd_no_cal", 32'(cal_pulses - base_cal), 32'd0);
        checkOutput("ignored_cmd_adc_pulses", 32'(adc_pulses - base_adc), 32'd4);

        $display("[TB] sys_locked dropped mid-stream");
        base_cal = cal_pulses; base_adc = adc_pulses;
        adc_vals = '{12'h321, 12'h654, 12'h987, 12'hCBA};
        exp_q = '{8'h03, 8'h21};
        applyStimulus(4'h2);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("lock_first_sample_sent", 32'(n < 300), 32'd1);
        sys_locked = 1'b0;
        @(negedge clk);
        checkOutput("lock_busy", 32'(busy), 32'd0);
        checkOutput("lock_tx_req", 32'(tx_req), 32'd0);
        checkOutput("lock_tx_data", 32'(tx_data), 32'd0);
        checkOutput("lock_adc_start", 32'(adc_start), 32'd0);
        applyStimulus(4'h1);
        checkOutput("unlocked_cmd_cal_start", 32'(cal_start), 32'd0);
        checkOutput("unlocked_cmd_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        checkOutput("lock_adc_pulses", 32'(adc_pulses - base_adc), 32'd1);
        checkOutput("lock_cal_pulses", 32'(cal_pulses - base_cal), 32'd0);
        adc_vals.delete();
        sys_locked = 1'b1;
        waitIdle(100);

        $display("[TB] cal_done on the timeout cycle");
        cal_delay = 21;
        exp_q.push_back(8'hA5);
        applyStimulus(4'h1);
        waitIdle(200);
        checkOutput("edge_done_err", 32'(err), 32'd0);

        $display("[TB] cal_done one cycle after timeout");
        cal_delay = 22;
        exp_q.push_back(8'hEE);
        applyStimulus(4'h1);
        waitIdle(200);
        checkOutput("late_done_err", 32'(err), 32'd1);

        $display("[TB] async reset mid-sequence");
        adc_auto = 1'b0;
        applyStimulus(4'h2);
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1;
        checkOutput("areset_busy", 32'(busy), 32'd0);
        checkOutput("areset_err", 32'(err), 32'd0);
        checkOutput("areset_adc_start", 32'(adc_start), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        cal_delay = 10;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        applyStimulus(4'h1);
        waitIdle(200);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
